// File: rtl/mem_access_unit.sv
// Memory-access stage: one LW/SW/LB/SB at a time between execute and
// write-back, driving an 8x16 register-file data memory directly.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        request handshake from execute
//   req_op/addr/wdata/rd       op (00 LW,01 SW,10 LB,11 SB), byte addr,
//                              store data, destination tag
//   resp_valid/resp_ready      response handshake to write-back
//   resp_data/rd/is_load/fault registered completion info
//   mem_wr_en/Addr/data        data-memory write port (commits on edge)
//   mem_read_en/rd_Addr        data-memory read port
//   mem_rd_data                combinational read data
module mem_access_unit #(
  parameter int MEM_WORDS   = 8,
  parameter int IDX_W       = 3,
  parameter int LB_SIGN_EXT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [2:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic [2:0]  resp_rd,
  output logic        resp_is_load,
  output logic        resp_fault,
  output logic        mem_wr_en,
  output logic [15:0] mem_wr_Addr,
  output logic [15:0] mem_wr_data,
  output logic        mem_read_en,
  output logic [15:0] mem_rd_Addr,
  input  logic [15:0] mem_rd_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  localparam logic [1:0] OP_LW = 2'b00;
  localparam logic [1:0] OP_SW = 2'b01;
  localparam logic [1:0] OP_LB = 2'b10;

  state_t           r_state;
  state_t           w_state_n;
  logic [1:0]       r_op;
  logic [IDX_W-1:0] r_idx;
  logic             r_lane;
  logic [15:0]      r_wdata;
  logic [2:0]       r_rd;
  logic             r_fault;
  logic             r_resp_valid;
  logic [15:0]      r_resp_data;
  logic [2:0]       r_resp_rd;
  logic             r_resp_is_load;
  logic             r_resp_fault;

  logic [IDX_W-1:0] w_idx;
  logic             w_hi_nz;
  logic             w_idx_oor;
  logic             w_align;
  logic             w_fault;
  logic [15:0]      w_idx_ext;
  logic [7:0]       w_byte;
  logic [15:0]      w_lb;
  logic [15:0]      w_merge;
  logic [15:0]      w_ld;

  // Request-side decode, evaluated on the raw request in IDLE.
  assign w_idx     = req_addr[IDX_W:1];
  assign w_hi_nz   = |req_addr[15:IDX_W+1];
  assign w_idx_oor = 32'(w_idx) >= 32'(MEM_WORDS);
  // Word ops must be halfword aligned; byte ops never misalign.
  assign w_align   = ~req_op[1] & req_addr[0];
  assign w_fault   = w_hi_nz | w_idx_oor | w_align;

  assign w_idx_ext = {{(16-IDX_W){1'b0}}, r_idx};

  assign w_byte = r_lane ? mem_rd_data[15:8] : mem_rd_data[7:0];
  assign w_lb   = (LB_SIGN_EXT != 0) ? {{8{w_byte[7]}}, w_byte}
                                     : {8'h00, w_byte};

  // SB read-modify-write: only the addressed lane is replaced.
  assign w_merge = r_lane ? {r_wdata[7:0], mem_rd_data[7:0]}
                          : {mem_rd_data[15:8], r_wdata[7:0]};

  always_comb begin
    w_ld = 16'h0000;
    if (!r_fault) begin
      if (r_op == OP_LW) w_ld = mem_rd_data;
      else if (r_op == OP_LB) w_ld = w_lb;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    req_ready   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wr_Addr = 16'h0000;
    mem_wr_data = 16'h0000;
    mem_read_en = 1'b0;
    mem_rd_Addr = 16'h0000;
    unique case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_n = S_EXEC;
      end
      S_EXEC: begin
        w_state_n = S_RESP;
        if (!r_fault) begin
          if (r_op != OP_SW) begin
            mem_read_en = 1'b1;
            mem_rd_Addr = w_idx_ext;
          end
          if (r_op[0]) begin
            mem_wr_en   = 1'b1;
            mem_wr_Addr = w_idx_ext;
            mem_wr_data = r_op[1] ? w_merge : r_wdata;
          end
        end
      end
      S_RESP: begin
        if (resp_ready) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_op           <= 2'b00;
      r_idx          <= '0;
      r_lane         <= 1'b0;
      r_wdata        <= 16'h0000;
      r_rd           <= 3'd0;
      r_fault        <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_resp_data    <= 16'h0000;
      r_resp_rd      <= 3'd0;
      r_resp_is_load <= 1'b0;
      r_resp_fault   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (r_state == S_IDLE && req_valid) begin
        r_op    <= req_op;
        r_idx   <= w_idx;
        r_lane  <= req_addr[0];
        r_wdata <= req_wdata;
        r_rd    <= req_rd;
        r_fault <= w_fault;
      end
      if (r_state == S_EXEC) begin
        r_resp_valid   <= 1'b1;
        r_resp_data    <= w_ld;
        r_resp_rd      <= r_rd;
        r_resp_is_load <= ~r_op[0];
        r_resp_fault   <= r_fault;
      end
      if (r_state == S_RESP && resp_ready) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  assign resp_valid   = r_resp_valid;
  assign resp_data    = r_resp_data;
  assign resp_rd      = r_resp_rd;
  assign resp_is_load = r_resp_is_load;
  assign resp_fault   = r_resp_fault;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: scoreboard of expected responses
// plus a behavioural 8x16 data memory and reference copy.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [2:0]  req_rd;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic [2:0]  resp_rd;
  logic        resp_is_load;
  logic        resp_fault;
  logic        mem_wr_en;
  logic [15:0] mem_wr_Addr;
  logic [15:0] mem_wr_data;
  logic        mem_read_en;
  logic [15:0] mem_rd_Addr;
  logic [15:0] mem_rd_data;

  logic        z_req_ready;
  logic        z_resp_valid;
  logic [15:0] z_resp_data;
  logic [2:0]  z_resp_rd;
  logic        z_resp_is_load;
  logic        z_resp_fault;
  logic        z_mem_wr_en;
  logic [15:0] z_mem_wr_Addr;
  logic [15:0] z_mem_wr_data;
  logic        z_mem_read_en;
  logic [15:0] z_mem_rd_Addr;

  logic [15:0] tb_mem [8];
  logic [15:0] ref_mem [8];
  int          wr_cnt;
  int          vecs;
  int          miss;

  typedef struct {
    logic [15:0] data;
    logic [15:0] zdata;
    logic [2:0]  rd;
    logic        ld;
    logic        flt;
  } exp_t;

  exp_t q[$];

  mem_access_unit #(.LB_SIGN_EXT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_rd(resp_rd),
    .resp_is_load(resp_is_load), .resp_fault(resp_fault),
    .mem_wr_en(mem_wr_en), .mem_wr_Addr(mem_wr_Addr),
    .mem_wr_data(mem_wr_data), .mem_read_en(mem_read_en),
    .mem_rd_Addr(mem_rd_Addr), .mem_rd_data(mem_rd_data)
  );

  // Zero-extending twin fed the same inputs and read data.
  mem_access_unit #(.LB_SIGN_EXT(0)) dut_z (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(z_req_ready),
    .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(z_resp_valid), .resp_ready(resp_ready),
    .resp_data(z_resp_data), .resp_rd(z_resp_rd),
    .resp_is_load(z_resp_is_load), .resp_fault(z_resp_fault),
    .mem_wr_en(z_mem_wr_en), .mem_wr_Addr(z_mem_wr_Addr),
    .mem_wr_data(z_mem_wr_data), .mem_read_en(z_mem_read_en),
    .mem_rd_Addr(z_mem_rd_Addr), .mem_rd_data(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd_data = tb_mem[mem_rd_Addr[2:0]];

  always @(posedge clk) begin
    if (mem_wr_en) begin
      tb_mem[mem_wr_Addr[2:0]] <= mem_wr_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic [1:0] op,
                        input logic [15:0] addr,
                        input logic [15:0] wd,
                        input logic [2:0] rd,
                        input int hold);
    exp_t e;
    logic flt;
    logic [2:0] idx;
    logic [7:0] b;
    logic [15:0] old;
    logic [15:0] wexp;
    logic went;
    logic got;
    idx  = addr[3:1];
    flt  = (addr[15:4] != 12'h000) || (!op[1] && addr[0]);
    old  = ref_mem[idx];
    b    = addr[0] ? old[15:8] : old[7:0];
    wexp = 16'h0000;
    went = !flt && op[0];
    e.rd = rd;
    e.ld = !op[0];
    e.flt = flt;
    e.data = 16'h0000;
    e.zdata = 16'h0000;
    if (!flt) begin
      case (op)
        2'b00: begin
          e.data = old;
          e.zdata = old;
        end
        2'b01: wexp = wd;
        2'b10: begin
          e.data = {{8{b[7]}}, b};
          e.zdata = {8'h00, b};
        end
        default: wexp = addr[0] ? {wd[7:0], old[7:0]}
                                : {old[15:8], wd[7:0]};
      endcase
      if (op[0]) ref_mem[idx] = wexp;
    end
    q.push_back(e);

    @(negedge clk);
    chk("req_ready_idle", {15'd0, req_ready}, 16'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    req_rd    = rd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("exec_wr_en", {15'd0, mem_wr_en}, {15'd0, went});
    chk("exec_rd_en", {15'd0, mem_read_en},
        {15'd0, !flt && op != 2'b01});
    if (went) begin
      chk("exec_wr_addr", mem_wr_Addr, {13'd0, idx});
      chk("exec_wr_data", mem_wr_data, wexp);
    end
    chk("exec_req_ready", {15'd0, req_ready}, 16'd0);

    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk("resp_timeout", 16'd0, 16'd1);
      void'(q.pop_front());
      return;
    end
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", {15'd0, resp_valid}, 16'd1);
      chk("hold_data", resp_data, q[0].data);
      chk("hold_req_ready", {15'd0, req_ready}, 16'd0);
      @(posedge clk);
      #1;
    end
    if (q.size() == 0) begin
      chk("sb_empty", 16'd0, 16'd1);
    end else begin
      e = q.pop_front();
      chk($sformatf("resp_data@%h", addr), resp_data, e.data);
      chk("resp_rd", {13'd0, resp_rd}, {13'd0, e.rd});
      chk("resp_is_load", {15'd0, resp_is_load}, {15'd0, e.ld});
      chk("resp_fault", {15'd0, resp_fault}, {15'd0, e.flt});
      if (op == 2'b10)
        chk("z_resp_data", z_resp_data, e.zdata);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk("post_valid", {15'd0, resp_valid}, 16'd0);
    chk("post_req_ready", {15'd0, req_ready}, 16'd1);
  endtask

  initial begin
    int saved;
    vecs = 0;
    miss = 0;
    wr_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tb_mem[i] = 16'h0000;
      ref_mem[i] = 16'h0000;
    end
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_op = 2'b00;
    req_addr = 16'h0000;
    req_wdata = 16'h0000;
    req_rd = 3'd0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {15'd0, req_ready}, 16'd1);
    chk("rst_resp_valid", {15'd0, resp_valid}, 16'd0);
    chk("rst_resp_data", resp_data, 16'd0);
    chk("rst_wr_en", {15'd0, mem_wr_en}, 16'd0);
    chk("rst_rd_en", {15'd0, mem_read_en}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_req(2'b01, 16'h0004, 16'hBEEF, 3'd1, 0);
    do_req(2'b00, 16'h0004, 16'h0000, 3'd2, 0);
    do_req(2'b11, 16'h0005, 16'h0012, 3'd3, 0);
    do_req(2'b00, 16'h0004, 16'h0000, 3'd4, 0);
    do_req(2'b01, 16'h0006, 16'h80FF, 3'd5, 0);
    do_req(2'b10, 16'h0007, 16'h0000, 3'd6, 0);
    do_req(2'b10, 16'h0006, 16'h0000, 3'd7, 0);
    saved = wr_cnt;
    do_req(2'b00, 16'h0003, 16'h0000, 3'd1, 0);
    do_req(2'b01, 16'h0010, 16'hDEAD, 3'd2, 0);
    do_req(2'b11, 16'h8001, 16'h00AA, 3'd3, 0);
    chk("fault_no_write", 16'(wr_cnt), 16'(saved));
    do_req(2'b00, 16'h0004, 16'h0000, 3'd5, 5);
    do_req(2'b11, 16'h000E, 16'h0034, 3'd6, 0);
    do_req(2'b10, 16'h000E, 16'h0000, 3'd7, 0);
    do_req(2'b10, 16'h000F, 16'h0000, 3'd0, 0);

    // Reset lands in EXEC of a store.
    saved = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 2'b01;
    req_addr = 16'h0008;
    req_wdata = 16'h1234;
    req_rd = 3'd3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_exec_ready", {15'd0, req_ready}, 16'd1);
    chk("rst_exec_wr_en", {15'd0, mem_wr_en}, 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("rst_no_resp", {15'd0, resp_valid}, 16'd0);
    end
    chk("rst_no_write", 16'(wr_cnt), 16'(saved));
    chk("rst_mem4", tb_mem[4], 16'h0000);
    do_req(2'b00, 16'h0008, 16'h0000, 3'd1, 0);
    do_req(2'b00, 16'h0004, 16'h0000, 3'd2, 0);

    for (int i = 0; i < 8; i++)
      chk($sformatf("mem[%0d]", i), tb_mem[i], ref_mem[i]);
    chk("sb_left", 16'(q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
